// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, requester FSM states and
// the watchdog width helper.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Watchdog counter width: enough bits to hold TIMEOUT, never narrower than 1.
    function automatic int wd_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command into SETUP/ACCESS transfers,
// returns read data and an error flag, and aborts stalled completers.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam bit              WD_EN   = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT - 1) : '0;

    apb_state_e        r_state;
    logic [WD_W-1:0]   r_wd;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_psel;
    logic              r_penable;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    apb_state_e        w_state_nxt;
    logic [WD_W-1:0]   w_wd_nxt;
    logic [ADDR_W-1:0] w_paddr_nxt;
    logic              w_pwrite_nxt;
    logic [DATA_W-1:0] w_pwdata_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              w_rsp_err_nxt;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_state_nxt     = r_state;
        w_wd_nxt        = r_wd;
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_paddr_nxt  = cmd_addr;
                    w_pwrite_nxt = cmd_write;
                    w_pwdata_nxt = cmd_wdata;
                    w_wd_nxt     = '0;
                    w_state_nxt  = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
                    w_rsp_err_nxt   = PSLVERR;
                    w_state_nxt     = IDLE;
                end else if (WD_EN && (r_wd == WD_LAST)) begin
                    // This stalled edge is the TIMEOUT-th one: abort with an error.
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = IDLE;
                end else if (WD_EN) begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_wd        <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wd        <= w_wd_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_psel      <= (w_state_nxt != IDLE);
            r_penable   <= (w_state_nxt == ACCESS);
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: scoreboarded responses, a completer
// model with programmable wait states, and hand-timed corner sequences.
module tb_apb_master;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_pen;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    int   checks = 0;
    int   errors = 0;
    rsp_t sb_q[$];
    int   rsp_seen = 0;

    // Completer behaviour attached to the command being driven.
    int          cmd_waits;
    logic [31:0] cmd_prdata;
    logic        cmd_slverr;

    // Values captured when the handshake completes.
    int          acc_count = 0;
    int          cyc = 0;
    int          acc_last_cyc = 0;
    int          acc_prev_cyc = 0;
    logic [31:0] a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        a_wr = 1'b0;
    int          a_waits = 0;
    logic [31:0] a_prdata = '0;
    logic        a_slverr = 1'b0;
    int          acc_n = 0;

    vec_t vecs[8];

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected one within the cycle budget", name);
    endtask

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (PRESETn && cmd_valid && cmd_ready) begin
            acc_count    <= acc_count + 1;
            acc_prev_cyc <= acc_last_cyc;
            acc_last_cyc <= cyc;
            a_addr       <= cmd_addr;
            a_wdata      <= cmd_wdata;
            a_wr         <= cmd_write;
            a_waits      <= cmd_waits;
            a_prdata     <= cmd_prdata;
            a_slverr     <= cmd_slverr;
        end
    end

    // Completer model: garbage on PRDATA/PSLVERR except on the ready cycle.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            acc_n   = 0;
            PREADY  = 1'b1;
            PRDATA  = 32'hBAD0_BAD0;
            PSLVERR = 1'b1;
        end else if (PSEL && PENABLE) begin
            if (acc_n == a_waits) begin
                PREADY  = 1'b1;
                PRDATA  = a_prdata;
                PSLVERR = a_slverr;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = ~a_prdata;
                PSLVERR = ~a_slverr;
            end
            acc_n++;
        end else begin
            if (PSEL) acc_n = 0;
            PREADY  = 1'b1;
            PRDATA  = 32'hBAD0_BAD0;
            PSLVERR = 1'b1;
        end
    end

    always @(negedge PCLK) begin : rsp_mon
        rsp_t e;
        if (PRESETn && rsp_valid) begin
            rsp_seen++;
            check("rsp_psel_low", PSEL, 0);
            check("rsp_cmd_ready", cmd_ready, 1);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    always @(negedge PCLK) begin
        if (PRESETn) begin
            check("penable_without_psel", PENABLE & ~PSEL, 0);
            check("busy_eq_psel", busy, PSEL);
            if (PSEL) begin
                check("paddr_stable", PADDR, a_addr);
                check("pwrite_stable", PWRITE, a_wr);
                if (a_wr) check("pwdata_stable", PWDATA, a_wdata);
            end
        end
    end

    task automatic drive_cmd(input vec_t v);
        cmd_valid  = 1'b1;
        cmd_write  = v.wr;
        cmd_addr   = v.addr;
        cmd_wdata  = v.wdata;
        cmd_waits  = v.waits;
        cmd_prdata = v.prdata;
        cmd_slverr = v.slverr;
    endtask

    task automatic push_exp(input vec_t v);
        rsp_t e;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
    endtask

    task automatic wait_accept(input int target);
        for (int k = 0; k < 20; k++) begin
            if (acc_count >= target) return;
            tick();
        end
        fail_bound("accept_timeout");
    endtask

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 40; k++) begin
            if (rsp_seen >= target) return;
            tick();
        end
        fail_bound("rsp_timeout");
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        int r;
        t = acc_count + 1;
        r = rsp_seen + 1;
        drive_cmd(v);
        push_exp(v);
        tick();
        wait_accept(t);
        cmd_valid = 1'b0;
        wait_rsp(r);
        check("access_cycles", acc_n, v.exp_pen);
        check("idle_paddr_hold", PADDR, v.addr);
        tick();
    endtask

    initial begin
        vec_t v;
        vec_t vb;
        int   t;
        int   r;

        //          wr    addr           wdata          waits prdata         err   exp_rdata      exp_err pen
        vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_0041, 0,   32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0,   1};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         3,   32'h0000_00A5, 1'b0, 32'h0000_00A5, 1'b0,   4};
        vecs[2] = '{1'b0, 32'h0000_000C, 32'h0,         0,   32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A, 1'b1,   1};
        vecs[3] = '{1'b1, 32'h0000_0010, 32'h0000_1234, 2,   32'h7777_7777, 1'b1, 32'h0,         1'b1,   3};
        vecs[4] = '{1'b0, 32'h0000_0014, 32'h0,         1,   32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0,   2};
        vecs[5] = '{1'b0, 32'h0000_0018, 32'h0,         100, 32'h1111_1111, 1'b0, 32'h0,         1'b1,   4};
        vecs[6] = '{1'b1, 32'h0000_001C, 32'hFFFF_0000, 100, 32'h2222_2222, 1'b0, 32'h0,         1'b1,   4};
        vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0,   32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0,   1};

        PRESETn    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_waits  = 0;
        cmd_prdata = '0;
        cmd_slverr = 1'b0;
        tick();
        tick();
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_psel", PSEL, 0);
        check("reset_penable", PENABLE, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_busy", busy, 0);
        check("reset_paddr", PADDR, 0);
        check("reset_pwrite", PWRITE, 0);
        check("reset_pwdata", PWDATA, 0);
        PRESETn = 1'b1;
        tick();

        // Zero-wait write, cycle by cycle.
        v = vecs[0];
        r = rsp_seen;
        drive_cmd(v);
        push_exp(v);
        tick();
        check("t1_psel", PSEL, 1);
        check("t1_penable", PENABLE, 0);
        check("t1_cmd_ready", cmd_ready, 0);
        check("t1_paddr", PADDR, 32'h4);
        check("t1_pwdata", PWDATA, 32'h41);
        check("t1_pwrite", PWRITE, 1);
        cmd_valid = 1'b0;
        tick();
        check("t2_psel", PSEL, 1);
        check("t2_penable", PENABLE, 1);
        check("t2_rsp_valid", rsp_valid, 0);
        tick();
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_penable", PENABLE, 0);
        check("t3_rsp_count", rsp_seen, r + 1);
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: command held valid across two transfers.
        v  = '{1'b0, 32'h20, 32'h0,  0, 32'h11, 1'b0, 32'h11, 1'b0, 1};
        vb = '{1'b1, 32'h24, 32'h22, 1, 32'h33, 1'b0, 32'h0,  1'b0, 2};
        t = acc_count;
        r = rsp_seen;
        drive_cmd(v);
        push_exp(v);
        push_exp(vb);
        tick();
        wait_accept(t + 1);
        drive_cmd(vb);
        wait_accept(t + 2);
        check("b2b_accept_gap", acc_last_cyc - acc_prev_cyc, 3);
        check("b2b_first_rsp_seen", rsp_seen, r + 1);
        cmd_valid = 1'b0;
        wait_rsp(r + 2);
        check("b2b_access_cycles", acc_n, vb.exp_pen);
        tick();

        // Reset asserted in the middle of ACCESS: no response may follow.
        v = '{1'b0, 32'h30, 32'h0, 100, 32'h44, 1'b0, 32'h0, 1'b1, 4};
        t = acc_count;
        r = rsp_seen;
        drive_cmd(v);
        tick();
        wait_accept(t + 1);
        cmd_valid = 1'b0;
        tick();
        check("rst_pre_penable", PENABLE, 1);
        PRESETn = 1'b0;
        #1;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        tick();
        PRESETn = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_no_rsp", rsp_seen, r);

        run_vec(vecs[4]);

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
